// File: rtl/pe_seq_ctrl_pkg.sv
// Shared types and helpers for the PE sequencer: operating modes, FSM states,
// kernel-direction bit positions and the packing of an index-buffer word.
package pe_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_FWD = 2'b00,
    MODE_BWD = 2'b01,
    MODE_GRD = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Kernel-direction bits inside kdir, matching the {top,bottom,left,right}
  // layout of pad_code so the two can be ANDed directly.
  localparam int KDIR_TOP    = 3;
  localparam int KDIR_BOTTOM = 2;
  localparam int KDIR_LEFT   = 1;
  localparam int KDIR_RIGHT  = 0;

  // Builds an index word {kdir, offset} for an offset field ba_w bits wide.
  function automatic logic [31:0] pack_idx_word(input logic [3:0] kdir,
                                                input logic [31:0] offset,
                                                input int ba_w);
    logic [31:0] mask;
    mask = (32'd1 << ba_w) - 32'd1;
    return ({28'd0, kdir} << ba_w) | (offset & mask);
  endfunction

  // Padding decision for one beat: any padded edge the kernel tap touches,
  // plus the bottom row when the last trip is cut short vertically.
  function automatic logic pad_hit(input logic [3:0] kdir,
                                   input logic [3:0] pad_code,
                                   input logic       cut_y,
                                   input logic       last_trip);
    return (|(kdir & pad_code)) | (cut_y & kdir[KDIR_BOTTOM] & last_trip);
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Job descriptor, job handshake and buffer-side signals of the PE sequencer.
// The master side is the sequencer; the slave side is the PE datapath/host.
interface pe_seq_ctrl_if #(
  parameter int IDX_DEPTH = 256,
  parameter int BUF_DEPTH = 256,
  parameter int TRIP_W    = 8
);
  localparam int IA_W = $clog2(IDX_DEPTH);
  localparam int BA_W = $clog2(BUF_DEPTH);

  // job control
  logic              start;
  logic              done;
  logic              busy;
  logic              err;
  logic [1:0]        mode;
  logic [IA_W-1:0]   idx_cnt;
  logic [TRIP_W-1:0] trip_cnt;
  logic              is_new;
  logic [3:0]        pad_code;
  logic              cut_y;

  // index buffer
  logic              idx_rd_en;
  logic [IA_W-1:0]   idx_rd_addr;
  logic [BA_W+3:0]   idx_rd_data;

  // operand and accumulate buffers
  logic              rd_valid;
  logic [BA_W-1:0]   dbuf_rd_addr;
  logic [BA_W-1:0]   pbuf_rd_addr;
  logic              pad_mask;
  logic              acc_clear;
  logic [BA_W-1:0]   abuf_rd_addr;
  logic              abuf_wr_en;
  logic [BA_W-1:0]   abuf_wr_addr;

  modport master (
    input  start, mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, idx_rd_data,
    output done, busy, err, idx_rd_en, idx_rd_addr, rd_valid, dbuf_rd_addr,
           pbuf_rd_addr, pad_mask, acc_clear, abuf_rd_addr, abuf_wr_en, abuf_wr_addr
  );

  modport slave (
    output start, mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, idx_rd_data,
    input  done, busy, err, idx_rd_en, idx_rd_addr, rd_valid, dbuf_rd_addr,
           pbuf_rd_addr, pad_mask, acc_clear, abuf_rd_addr, abuf_wr_en, abuf_wr_addr
  );

endinterface

// File: rtl/pe_seq_ctrl_delay.sv
// Fixed-depth shift register used to align accumulate-buffer writebacks with
// the MAC pipeline. Reset empties it so in-flight writebacks are dropped.
module pe_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next value of every stage: new entry at the head, everything moves one on.
  always_comb begin
    stage_d[0] = din;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Stage registers, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: walks the sparse index buffer once per trip and turns each
// index into operand addresses, padding masks, accumulator clears and
// MAC-latency-aligned accumulate-buffer writebacks, then pulses done.
module pe_seq_ctrl
  import pe_seq_ctrl_pkg::*;
#(
  parameter int IDX_DEPTH   = 256,
  parameter int BUF_DEPTH   = 256,
  parameter int TRIP_W      = 8,
  parameter int MAC_LAT     = 3,
  parameter int TRIP_STRIDE = 16
) (
  input  logic          clk,
  input  logic          rst,
  pe_seq_ctrl_if.master bus
);

  localparam int IA_W = $clog2(IDX_DEPTH);
  localparam int BA_W = $clog2(BUF_DEPTH);
  localparam int DR_W = 4;
  localparam int WB_W = BA_W + 1;

  state_e            state_q,    state_d;
  logic [IA_W-1:0]   i_q,        i_d;
  logic [TRIP_W-1:0] t_q,        t_d;
  logic [DR_W-1:0]   drain_q,    drain_d;
  mode_e             mode_q,     mode_d;
  logic [IA_W-1:0]   idx_cnt_q,  idx_cnt_d;
  logic [TRIP_W-1:0] trip_cnt_q, trip_cnt_d;
  logic              is_new_q,   is_new_d;
  logic [3:0]        pad_code_q, pad_code_d;
  logic              cut_y_q,    cut_y_d;
  logic              err_q,      err_d;
  logic              beat_valid_q, beat_valid_d;
  logic [IA_W-1:0]   beat_i_q,   beat_i_d;
  logic [TRIP_W-1:0] beat_t_q,   beat_t_d;

  logic [BA_W-1:0] offset;
  logic [3:0]      kdir;
  logic [BA_W-1:0] beat_base;
  logic [BA_W-1:0] beat_i_ba;
  logic [BA_W-1:0] beat_t_ba;
  logic            first_idx, last_idx, first_trip, last_trip;

  logic [BA_W-1:0] dbuf_addr, pbuf_addr, abuf_rd;
  logic            pad, clr;
  logic [WB_W-1:0] wb_in, wb_out;

  // Job FSM and counters: descriptor capture, index/trip walk, pipeline drain.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    t_d          = t_q;
    drain_d      = drain_q;
    mode_d       = mode_q;
    idx_cnt_d    = idx_cnt_q;
    trip_cnt_d   = trip_cnt_q;
    is_new_d     = is_new_q;
    pad_code_d   = pad_code_q;
    cut_y_d      = cut_y_q;
    err_d        = 1'b0;
    beat_valid_d = 1'b0;
    beat_i_d     = i_q;
    beat_t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (mode_e'(bus.mode) == MODE_ILL) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            mode_d     = mode_e'(bus.mode);
            idx_cnt_d  = bus.idx_cnt;
            trip_cnt_d = bus.trip_cnt;
            is_new_d   = bus.is_new;
            pad_code_d = bus.pad_code;
            cut_y_d    = bus.cut_y;
            i_d        = '0;
            t_d        = '0;
          end
        end
      end
      ST_RUN: begin
        beat_valid_d = 1'b1;
        if (i_q == idx_cnt_q) begin
          i_d = '0;
          if (t_q == trip_cnt_q) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            t_d = t_q + TRIP_W'(1);
          end
        end else begin
          i_d = i_q + IA_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DR_W'(MAC_LAT)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and descriptor registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      i_q          <= '0;
      t_q          <= '0;
      drain_q      <= '0;
      mode_q       <= MODE_FWD;
      idx_cnt_q    <= '0;
      trip_cnt_q   <= '0;
      is_new_q     <= 1'b0;
      pad_code_q   <= '0;
      cut_y_q      <= 1'b0;
      err_q        <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_i_q     <= '0;
      beat_t_q     <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      t_q          <= t_d;
      drain_q      <= drain_d;
      mode_q       <= mode_d;
      idx_cnt_q    <= idx_cnt_d;
      trip_cnt_q   <= trip_cnt_d;
      is_new_q     <= is_new_d;
      pad_code_q   <= pad_code_d;
      cut_y_q      <= cut_y_d;
      err_q        <= err_d;
      beat_valid_q <= beat_valid_d;
      beat_i_q     <= beat_i_d;
      beat_t_q     <= beat_t_d;
    end
  end

  assign offset     = bus.idx_rd_data[BA_W-1:0];
  assign kdir       = bus.idx_rd_data[BA_W+3:BA_W];
  assign beat_base  = BA_W'(beat_t_q * TRIP_STRIDE);
  assign beat_i_ba  = BA_W'(beat_i_q);
  assign beat_t_ba  = BA_W'(beat_t_q);
  assign first_idx  = (beat_i_q == '0);
  assign last_idx   = (beat_i_q == idx_cnt_q);
  assign first_trip = (beat_t_q == '0);
  assign last_trip  = (beat_t_q == trip_cnt_q);

  // Beat decode: the index word returned this cycle becomes operand
  // addresses, padding and accumulation control; idle beats drive zeros.
  always_comb begin
    dbuf_addr = '0;
    pbuf_addr = '0;
    abuf_rd   = '0;
    pad       = 1'b0;
    clr       = 1'b0;
    wb_in     = '0;
    if (beat_valid_q) begin
      if (mode_q == MODE_BWD) begin
        dbuf_addr = beat_base + beat_i_ba;
        pbuf_addr = offset;
      end else begin
        dbuf_addr = beat_base + offset;
        pbuf_addr = beat_i_ba;
      end
      pad = pad_hit(kdir, pad_code_q, cut_y_q, last_trip);
      if (mode_q == MODE_GRD) begin
        clr     = is_new_q & first_trip;
        abuf_rd = beat_i_ba;
        wb_in   = {1'b1, beat_i_ba};
      end else begin
        clr = is_new_q & first_idx;
        if (!is_new_q && first_idx) begin
          abuf_rd = beat_t_ba;
        end
        wb_in = {last_idx, beat_t_ba};
      end
    end
  end

  pe_delay_line #(
    .DEPTH (MAC_LAT),
    .WIDTH (WB_W)
  ) u_wb_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (wb_in),
    .dout (wb_out)
  );

  assign bus.busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done         = (state_q == ST_DONE) || err_q;
  assign bus.err          = err_q;
  assign bus.idx_rd_en    = (state_q == ST_RUN);
  assign bus.idx_rd_addr  = (state_q == ST_RUN) ? i_q : '0;
  assign bus.rd_valid     = beat_valid_q;
  assign bus.dbuf_rd_addr = dbuf_addr;
  assign bus.pbuf_rd_addr = pbuf_addr;
  assign bus.pad_mask     = pad;
  assign bus.acc_clear    = clr;
  assign bus.abuf_rd_addr = abuf_rd;
  assign bus.abuf_wr_en   = wb_out[BA_W];
  assign bus.abuf_wr_addr = wb_out[BA_W] ? wb_out[BA_W-1:0] : '0;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: each job pushes its expected beats, the
// monitor pops and compares them and times every writeback against MAC_LAT.
module tb_pe_seq_ctrl;
  import pe_seq_ctrl_pkg::*;

  localparam int IDX_DEPTH   = 256;
  localparam int BUF_DEPTH   = 256;
  localparam int TRIP_W      = 8;
  localparam int MAC_LAT     = 3;
  localparam int TRIP_STRIDE = 16;
  localparam int IA_W        = $clog2(IDX_DEPTH);
  localparam int BA_W        = $clog2(BUF_DEPTH);
  localparam int IDXW        = BA_W + 4;
  localparam int BUDGET      = 4000;

  typedef struct {
    int dbuf;
    int pbuf;
    int pad;
    int clr;
    int abrd;
    int wb;
    int wb_addr;
  } beat_t;

  typedef struct {
    int cyc;
    int addr;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pe_seq_ctrl_if #(.IDX_DEPTH(IDX_DEPTH), .BUF_DEPTH(BUF_DEPTH), .TRIP_W(TRIP_W)) bus ();

  pe_seq_ctrl #(
    .IDX_DEPTH   (IDX_DEPTH),
    .BUF_DEPTH   (BUF_DEPTH),
    .TRIP_W      (TRIP_W),
    .MAC_LAT     (MAC_LAT),
    .TRIP_STRIDE (TRIP_STRIDE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [IDXW-1:0] idx_mem [IDX_DEPTH];

  // Index buffer model with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.idx_rd_en) bus.idx_rd_data <= idx_mem[bus.idx_rd_addr];
  end

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_beats[$];
  wb_t   pend_wb[$];
  bit    mon_en = 1'b0;
  int    cyc = 0;
  int    beat_seen = 0;
  beat_t mon_b;
  wb_t   mon_w;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // Monitor: compare each beat against the scoreboard and each writeback
  // against the cycle it was scheduled for.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (pend_wb.size() > 0 && pend_wb[0].cyc == cyc) begin
        mon_w = pend_wb.pop_front();
        checkOutput("abuf_wr_en", 32'(bus.abuf_wr_en), 1);
        checkOutput("abuf_wr_addr", 32'(bus.abuf_wr_addr), mon_w.addr);
      end else if (bus.abuf_wr_en) begin
        checkOutput("abuf_wr_unexpected", 32'(bus.abuf_wr_en), 0);
      end
      if (bus.rd_valid) begin
        beat_seen++;
        if (exp_beats.size() == 0) begin
          checkOutput("rd_valid_extra", 32'(bus.rd_valid), 0);
        end else begin
          mon_b = exp_beats.pop_front();
          checkOutput("dbuf_rd_addr", 32'(bus.dbuf_rd_addr), mon_b.dbuf);
          checkOutput("pbuf_rd_addr", 32'(bus.pbuf_rd_addr), mon_b.pbuf);
          checkOutput("pad_mask", 32'(bus.pad_mask), mon_b.pad);
          checkOutput("acc_clear", 32'(bus.acc_clear), mon_b.clr);
          checkOutput("abuf_rd_addr", 32'(bus.abuf_rd_addr), mon_b.abrd);
          if (mon_b.wb != 0) begin
            mon_w.cyc  = cyc + MAC_LAT;
            mon_w.addr = mon_b.wb_addr;
            pend_wb.push_back(mon_w);
          end
        end
      end
    end
  end

  task automatic loadIdx(input int i, input logic [3:0] kdir, input int offset);
    idx_mem[i] = IDXW'(pack_idx_word(kdir, offset, BA_W));
  endtask

  task automatic pushExpected(input logic [1:0] mode, input int idx, input int trip,
                              input logic is_new, input logic [3:0] pad, input logic cut);
    beat_t           b;
    logic [IDXW-1:0] w;
    logic [3:0]      kd;
    int              off;
    int              base;
    for (int t = 0; t <= trip; t++) begin
      for (int i = 0; i <= idx; i++) begin
        w    = idx_mem[i];
        off  = int'(w[BA_W-1:0]);
        kd   = w[BA_W+3:BA_W];
        base = (t * TRIP_STRIDE) % BUF_DEPTH;
        if (mode == 2'b01) begin
          b.dbuf = (base + i) % BUF_DEPTH;
          b.pbuf = off;
        end else begin
          b.dbuf = (base + off) % BUF_DEPTH;
          b.pbuf = i % BUF_DEPTH;
        end
        b.pad = ((kd & pad) != 4'd0 || (cut && kd[KDIR_BOTTOM] && t == trip)) ? 1 : 0;
        if (mode == 2'b10) begin
          b.clr     = (is_new && t == 0) ? 1 : 0;
          b.abrd    = i % BUF_DEPTH;
          b.wb      = 1;
          b.wb_addr = i % BUF_DEPTH;
        end else begin
          b.clr     = (is_new && i == 0) ? 1 : 0;
          b.abrd    = (!is_new && i == 0) ? (t % BUF_DEPTH) : 0;
          b.wb      = (i == idx) ? 1 : 0;
          b.wb_addr = t % BUF_DEPTH;
        end
        exp_beats.push_back(b);
      end
    end
  endtask

  // Runs one legal job end to end; optionally pokes start while busy.
  task automatic applyStimulus(input string name, input logic [1:0] mode, input int idx, input int trip,
                               input logic is_new, input logic [3:0] pad, input logic cut, input bit poke);
    int busy_cnt = 0;
    int err_cnt  = 0;
    int extra    = 0;
    bit done_seen = 1'b0;
    $display("[TB] job %s", name);
    pushExpected(mode, idx, trip, is_new, pad, cut);
    beat_seen = 0;
    mon_en    = 1'b1;
    @(posedge clk); #1;
    bus.mode     = mode;
    bus.idx_cnt  = IA_W'(idx);
    bus.trip_cnt = TRIP_W'(trip);
    bus.is_new   = is_new;
    bus.pad_code = pad;
    bus.cut_y    = cut;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.mode     = 2'b11;
    bus.idx_cnt  = ~bus.idx_cnt;
    bus.trip_cnt = ~bus.trip_cnt;
    bus.is_new   = ~is_new;
    bus.pad_code = ~pad;
    bus.cut_y    = ~cut;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (poke && n == 5) bus.start = 1'b1;
      if (poke && n == 6) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.err) err_cnt++;
      if (bus.done) begin
        done_seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 32'(done_seen), 1);
    checkOutput("busy_cycles", busy_cnt, (idx + 1) * (trip + 1) + MAC_LAT + 1);
    checkOutput("busy_at_done", 32'(bus.busy), 0);
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra++;
      if (bus.err) err_cnt++;
      if (bus.busy) extra++;
    end
    checkOutput("extra_done_or_busy", extra, 0);
    checkOutput("err_count", err_cnt, 0);
    checkOutput("beat_count", beat_seen, (idx + 1) * (trip + 1));
    checkOutput("beats_left", exp_beats.size(), 0);
    checkOutput("wb_left", pend_wb.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({bus.rd_valid, bus.idx_rd_en, bus.busy, bus.done, bus.err,
                                     bus.abuf_wr_en, bus.acc_clear, bus.pad_mask}), 0);
    checkOutput({tag, "_addr"}, 32'({bus.idx_rd_addr, bus.dbuf_rd_addr, bus.pbuf_rd_addr}), 0);
    checkOutput({tag, "_abuf"}, 32'({bus.abuf_rd_addr, bus.abuf_wr_addr}), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stray;
    bus.start = 1'b0; bus.mode = 2'b00; bus.idx_cnt = '0; bus.trip_cnt = '0;
    bus.is_new = 1'b0; bus.pad_code = '0; bus.cut_y = 1'b0;
    for (int i = 0; i < IDX_DEPTH; i++) idx_mem[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // forward, 16 indices x 4 trips, with an ignored start while busy
    for (int i = 0; i < 16; i++) loadIdx(i, 4'b0000, i);
    applyStimulus("fwd_16x4", 2'b00, 15, 3, 1'b1, 4'b0000, 1'b0, 1'b1);

    // illegal mode: err and done the next cycle, nothing issued
    @(posedge clk); #1;
    bus.mode = 2'b11; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("ill_err", 32'(bus.err), 1);
    checkOutput("ill_done", 32'(bus.done), 1);
    checkOutput("ill_rd_en", 32'(bus.idx_rd_en), 0);
    checkOutput("ill_busy", 32'(bus.busy), 0);
    @(negedge clk);
    checkOutput("ill_err_after", 32'({bus.err, bus.done, bus.idx_rd_en}), 0);

    // reset mid-run, with a start pulse while busy
    @(posedge clk); #1;
    bus.mode = 2'b00; bus.idx_cnt = IA_W'(15); bus.trip_cnt = TRIP_W'(3);
    bus.is_new = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(bus.busy), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #2 rst = 1'b0;
    #1 checkIdleOutputs("midrun_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.rd_valid || bus.abuf_wr_en) stray++;
    end
    checkOutput("post_reset_quiet", stray, 0);
    exp_beats.delete();
    pend_wb.delete();

    // backward after reset, summing onto abuf
    loadIdx(0, 4'b0000, 9); loadIdx(1, 4'b0000, 5);
    loadIdx(2, 4'b0000, 2); loadIdx(3, 4'b0000, 7);
    applyStimulus("bwd_4x1", 2'b01, 3, 0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // gradient, accumulating across trips
    loadIdx(0, 4'b0000, 20); loadIdx(1, 4'b0000, 30); loadIdx(2, 4'b0000, 40);
    applyStimulus("grd_3x2", 2'b10, 2, 1, 1'b0, 4'b0000, 1'b0, 1'b0);

    // padding: top edge padded, bottom row cut on the last trip
    loadIdx(0, 4'b0010, 3); loadIdx(1, 4'b0100, 4);
    loadIdx(2, 4'b1000, 5); loadIdx(3, 4'b0001, 6);
    applyStimulus("pad_4x2", 2'b00, 3, 1, 1'b1, 4'b1000, 1'b1, 1'b0);

    // single index, single trip
    loadIdx(0, 4'b0000, 200);
    applyStimulus("fwd_1x1", 2'b00, 0, 0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // base wraps past the end of the buffers
    loadIdx(0, 4'b0000, 250); loadIdx(1, 4'b0000, 255);
    applyStimulus("fwd_wrap", 2'b00, 1, 20, 1'b1, 4'b0000, 1'b0, 1'b0);

    // full-depth index walk, random taps and padding
    for (int i = 0; i < IDX_DEPTH; i++) loadIdx(i, 4'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    applyStimulus("grd_full", 2'b10, IDX_DEPTH - 1, 1, 1'b1, 4'b0101, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
